ddr3_wr_burst: RTL and testbench
================================

Name: ddr3_wr_burst

Overview:
- Sits downstream of the video-pixel dual-clock FIFO, on the afi_clk side.
- Watches the FIFO read-side fill level, pulls one burst of 64-bit words into a local buffer, then writes that burst to the DDR3 controller's Avalon-MM port.
- Walks a linear frame buffer in DDR3 and restarts at the base address on every frame_start.

Parameters:
- DATA_W, 64, FIFO word and Avalon data width.
- ADDR_W, 25, Avalon word-address width.
- BURST_LEN, 16, beats per Avalon burst; power of 2, 2..64.
- FRAME_BEATS, 61440, 64-bit words per frame; must be a multiple of BURST_LEN.
- BASE_ADDR, 0, first word address of the frame buffer.

Ports:
- afi_clk  in  1  single clock (DDR3 controller user clock).
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse, afi_clk domain: arm or restart the frame.
- fifo_rd_usedw  in  8  FIFO read-side used-word count.
- fifo_rd_req  out  1  FIFO read request; normal-mode FIFO, so q is valid 1 cycle after the request.
- fifo_data  in  DATA_W  FIFO q.
- avl_ready  in  1  controller ready; a beat is accepted when avl_write_req && avl_ready.
- avl_write_req  out  1  write request.
- avl_burstbegin  out  1  high on the first beat of each burst.
- avl_addr  out  ADDR_W  burst start word address.
- avl_size  out  7  burst length (= BURST_LEN).
- avl_wdata  out  DATA_W  write data.
- avl_be  out  DATA_W/8  byte enables; all ones.
- busy  out  1  high when not in IDLE.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; armed=0; pending_start=0.
  - addr register=BASE_ADDR; frame beat counter=FRAME_BEATS.
  - Outputs: fifo_rd_req=0, avl_write_req=0, avl_burstbegin=0, avl_wdata=0, busy=0, frame_done=0.
  - avl_size=BURST_LEN and avl_be=all ones are constant.
  - Reset mid-burst abandons the burst immediately with no completion.
- frame_start:
  - In IDLE: armed=1, addr=BASE_ADDR, counter=FRAME_BEATS, applied the next cycle.
  - In FILL or WRITE: latched into pending_start; applied on return to IDLE, so the current burst completes at its old address.
- States:
  - IDLE -> FILL when armed && counter!=0 && fifo_rd_usedw >= BURST_LEN && !pending_start. A pending_start is applied first in IDLE, costing one cycle.
  - FILL:
    - fifo_rd_req=1 for exactly BURST_LEN consecutive cycles.
    - fifo_data is captured into local buffer entry i one cycle after request i.
    - After the last capture (BURST_LEN+1 cycles in FILL) -> WRITE.
    - The FIFO never underflows, because the IDLE check guarantees enough words.
  - WRITE:
    - avl_write_req=1; avl_addr is held at the burst start address.
    - avl_wdata=buffer[beat]; avl_burstbegin=1 only while beat==0.
    - beat increments only on an accepted beat. avl_wdata, avl_addr and avl_burstbegin stay stable while avl_ready=0.
    - After beat BURST_LEN-1 is accepted: avl_write_req drops the next cycle, addr += BURST_LEN, counter -= BURST_LEN.
    - If the counter becomes 0: frame_done=1 for one cycle and armed=0. Otherwise stay armed.
    - Then -> IDLE.
- Address arithmetic:
  - Unsigned ADDR_W bits; addresses never exceed BASE_ADDR+FRAME_BEATS-1.
  - Wrap to BASE_ADDR happens only via frame_start. If no frame_start arrives, the block idles when the frame is complete.
- Throughput: minimum burst period is 1 (IDLE) + BURST_LEN+1 (FILL) + BURST_LEN (WRITE) cycles when avl_ready is held high.
- A FIFO aclr (upstream frame-boundary clear) is seen only as a drop in fifo_rd_usedw. The block relies on frame_start arriving for that same boundary.

Test Plan:
- Reset then frame_start, FIFO holding 20 incrementing words 0..19, avl_ready=1 -> one burst at addr 0:
  - wdata 0..15, burstbegin on beat 0 only.
  - fifo_rd_req high for 16 cycles.
  - Block returns to IDLE with 4 words left in the FIFO and the next burst not started.
- Same setup with avl_ready toggling 1,0,0,1,... -> exactly 16 accepted beats in order; wdata and addr stable during stalls; no extra FIFO reads.
- FRAME_BEATS=32, 40 words available -> bursts at addr 0 and 16; frame_done pulses once after the 32nd accepted beat; the block then idles with fifo_rd_usedw=8.
- frame_start during WRITE of the burst at addr 16 -> that burst completes at 16; the next burst starts at BASE_ADDR with the counter reloaded; no frame_done.
- rst asserted during FILL (after 5 reads) -> next cycle all outputs are at reset values; no write occurs until a new frame_start.
- fifo_rd_usedw=15 with BURST_LEN=16 -> no fifo_rd_req for 100 cycles; raising it to 16 -> FILL starts within 2 cycles.

Source files
------------

// File: rtl/ddr3_wr_burst.sv
// ddr3_wr_burst
//   Pulls one burst of words from the video-pixel FIFO (read side, afi_clk
//   domain) into a local buffer, then writes that burst to the DDR3
//   controller's Avalon-MM port. It walks a linear frame buffer starting at
//   BASE_ADDR and restarts at the base address on every frame_start.
//
// Ports
//   afi_clk, rst         : clock, synchronous active-high reset
//   frame_start          : one-cycle pulse, arm or restart the frame
//   fifo_rd_usedw        : FIFO read-side fill level
//   fifo_rd_req/fifo_data: FIFO read request / q (valid one cycle after request)
//   avl_ready            : controller ready; a beat moves on write_req && ready
//   avl_write_req, avl_burstbegin, avl_addr, avl_size, avl_wdata, avl_be
//                        : Avalon-MM burst write master
//   busy                 : high when not in IDLE
//   frame_done           : one-cycle pulse after the last beat of a frame
//
// state | meaning
// IDLE  | wait for armed frame with a full burst available in the FIFO
// FILL  | BURST_LEN read requests, capture each word one cycle later
// WRITE | present buffered burst to the controller, beat by beat

module ddr3_wr_burst #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 25,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 61440,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  afi_clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [7:0]            fifo_rd_usedw,
  output logic                  fifo_rd_req,
  input  logic [DATA_W-1:0]     fifo_data,
  input  logic                  avl_ready,
  output logic                  avl_write_req,
  output logic                  avl_burstbegin,
  output logic [ADDR_W-1:0]     avl_addr,
  output logic [6:0]            avl_size,
  output logic [DATA_W-1:0]     avl_wdata,
  output logic [DATA_W/8-1:0]   avl_be,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(BURST_LEN);
  localparam int CW = $clog2(FRAME_BEATS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [BW:0]       FILL_LAST = (BW+1)'(BURST_LEN);
  localparam logic [BW:0]       ONE_F     = (BW+1)'(1);
  localparam logic [BW-1:0]     BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0]     ONE_B     = BW'(1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);
  localparam logic [CW-1:0]     CNT_INIT  = CW'(FRAME_BEATS);
  localparam logic [CW-1:0]     CNT_STEP  = CW'(BURST_LEN);
  localparam logic [7:0]        LVL_NEED  = 8'(BURST_LEN);

  logic [1:0]        state;
  logic              armed;
  logic              pending_start;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     beats_left;
  logic [BW:0]       fill_cnt;
  logic [BW-1:0]     beat;
  logic              cap_vld;
  logic [BW-1:0]     cap_idx;
  logic [DATA_W-1:0] buf_mem [BURST_LEN];

  // fill_cnt counts 0..BURST_LEN; its top bit marks the capture-only cycle.
  assign fifo_rd_req    = (state == FILL) && !fill_cnt[BW];
  // Word i lands while fill_cnt == i+1 (the request is one cycle older).
  assign cap_idx        = fill_cnt[BW-1:0] - ONE_B;

  assign avl_write_req  = (state == WRITE);
  assign avl_burstbegin = (state == WRITE) && (beat == '0);
  assign avl_wdata      = (state == WRITE) ? buf_mem[beat] : '0;
  assign avl_addr       = addr_q;
  assign avl_size       = 7'(BURST_LEN);
  assign avl_be         = '1;
  assign busy           = (state != IDLE);

  always_ff @(posedge afi_clk) begin
    if (rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      pending_start <= 1'b0;
      addr_q        <= ADDR_BASE;
      beats_left    <= CNT_INIT;
      fill_cnt      <= '0;
      beat          <= '0;
      cap_vld       <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cap_vld    <= fifo_rd_req;
      case (state)
        IDLE: begin
          // A restart always wins over starting a burst, so a burst never
          // begins at a stale address.
          if (frame_start || pending_start) begin
            armed         <= 1'b1;
            pending_start <= 1'b0;
            addr_q        <= ADDR_BASE;
            beats_left    <= CNT_INIT;
          end else if (armed && (beats_left != '0) && (fifo_rd_usedw >= LVL_NEED)) begin
            state    <= FILL;
            fill_cnt <= '0;
          end
        end
        FILL: begin
          if (frame_start) pending_start <= 1'b1;
          if (fill_cnt == FILL_LAST) begin
            state <= WRITE;
            beat  <= '0;
          end else begin
            fill_cnt <= fill_cnt + ONE_F;
          end
        end
        WRITE: begin
          if (frame_start) pending_start <= 1'b1;
          if (avl_ready) begin
            if (beat == BEAT_LAST) begin
              state      <= IDLE;
              addr_q     <= addr_q + ADDR_STEP;
              beats_left <= beats_left - CNT_STEP;
              if (beats_left == CNT_STEP) begin
                frame_done <= 1'b1;
                armed      <= 1'b0;
              end
            end else begin
              beat <= beat + ONE_B;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge afi_clk) begin
    if (cap_vld) buf_mem[cap_idx] <= fifo_data;
  end

endmodule

// File: tb/tb_ddr3_wr_burst.sv
// Testbench for ddr3_wr_burst.
// Instance a uses the default frame size, instance b a 32-beat frame.
// A behavioural FIFO supplies incrementing words; each read pushes the word
// into a scoreboard that is popped on every accepted Avalon beat.

module tb_ddr3_wr_burst;

  localparam int BL = 16;

  logic        clk;
  logic        rst;
  logic        fs_a, fs_b;
  logic [7:0]  usedw;
  logic [63:0] fifo_data;
  logic        avl_ready;

  logic        rd_a, wr_a, bb_a, busy_a, done_a;
  logic [24:0] addr_a;
  logic [6:0]  size_a;
  logic [63:0] wdata_a;
  logic [7:0]  be_a;
  logic        rd_b, wr_b, bb_b, busy_b, done_b;
  logic [24:0] addr_b;
  logic [6:0]  size_b;
  logic [63:0] wdata_b;
  logic [7:0]  be_b;

  ddr3_wr_burst dut_a (
    .afi_clk(clk), .rst(rst), .frame_start(fs_a), .fifo_rd_usedw(usedw),
    .fifo_rd_req(rd_a), .fifo_data(fifo_data), .avl_ready(avl_ready),
    .avl_write_req(wr_a), .avl_burstbegin(bb_a), .avl_addr(addr_a),
    .avl_size(size_a), .avl_wdata(wdata_a), .avl_be(be_a),
    .busy(busy_a), .frame_done(done_a)
  );

  ddr3_wr_burst #(.FRAME_BEATS(32)) dut_b (
    .afi_clk(clk), .rst(rst), .frame_start(fs_b), .fifo_rd_usedw(usedw),
    .fifo_rd_req(rd_b), .fifo_data(fifo_data), .avl_ready(avl_ready),
    .avl_write_req(wr_b), .avl_burstbegin(bb_b), .avl_addr(addr_b),
    .avl_size(size_b), .avl_wdata(wdata_b), .avl_be(be_b),
    .busy(busy_b), .frame_done(done_b)
  );

  logic        sel;
  logic        s_rd, s_wr, s_bb, s_busy, s_done;
  logic [24:0] s_addr;
  logic [63:0] s_wdata;
  assign s_rd    = sel ? rd_b    : rd_a;
  assign s_wr    = sel ? wr_b    : wr_a;
  assign s_bb    = sel ? bb_b    : bb_a;
  assign s_busy  = sel ? busy_b  : busy_a;
  assign s_done  = sel ? done_b  : done_a;
  assign s_addr  = sel ? addr_b  : addr_a;
  assign s_wdata = sel ? wdata_b : wdata_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned rd_ptr = 0;
  int unsigned wr_ptr = 0;
  int          rd_count, acc_count, fd_count, fd_at, tb_beat, cyc;
  int unsigned exp_addr;
  logic        ready_mode;
  logic [63:0] exp_q[$];

  typedef struct {
    int   lvl;
    int   cycles;
    int   exp_rd;
    logic exp_busy;
  } vec_t;
  vec_t vecs[4];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: write beat with empty scoreboard, want none", name);
  endtask

  task automatic set_level(input int n);
    wr_ptr = rd_ptr + n;
    usedw  = 8'(wr_ptr - rd_ptr);
  endtask

  // One clock: sample at negedge, model FIFO/scoreboard, drive after posedge.
  task automatic tick();
    logic rd_now;
    @(negedge clk);
    rd_now = s_rd;
    if (s_done) begin
      fd_count++;
      fd_at = acc_count;
    end
    if (s_wr) begin
      if (exp_q.size() == 0) begin
        fail_now("sb_empty");
      end else begin
        check_eq("wdata", s_wdata, exp_q[0]);
        check_eq("addr", 64'(s_addr), 64'(exp_addr));
        check_eq("burstbegin", 64'(s_bb), 64'(tb_beat == 0));
        if (avl_ready) begin
          void'(exp_q.pop_front());
          acc_count++;
          tb_beat++;
          if (tb_beat == BL) begin
            tb_beat  = 0;
            exp_addr = exp_addr + BL;
          end
        end
      end
    end
    if (rd_now) begin
      rd_count++;
      exp_q.push_back(64'(rd_ptr));
    end
    @(posedge clk);
    #1;
    if (rd_now) begin
      fifo_data = 64'(rd_ptr);
      rd_ptr++;
    end
    usedw = 8'(wr_ptr - rd_ptr);
    cyc++;
    avl_ready = ready_mode ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tb_beat   = 0;
    rd_count  = 0;
    acc_count = 0;
    fd_count  = 0;
    fd_at     = -1;
    exp_addr  = 0;
  endtask

  task automatic pulse(input logic which);
    if (which) fs_b = 1'b1;
    else       fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    fs_b = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int max, input string name);
    int k = 0;
    while (s_busy !== val && k < max) begin
      tick();
      k++;
    end
    check_eq(name, 64'(s_busy), 64'(val));
  endtask

  task automatic wait_acc(input int n, input int max, input string name);
    int k = 0;
    while (acc_count < n && k < max) begin
      tick();
      k++;
    end
    check_eq(name, 64'(acc_count), 64'(n));
  endtask

  task automatic check_rst(input string tag, input logic rd, input logic wr, input logic bb,
                           input logic [63:0] wd, input logic bz, input logic dn,
                           input logic [6:0] sz, input logic [7:0] be, input logic [24:0] ad);
    check_eq({tag, "_rd_req"}, 64'(rd), 64'(0));
    check_eq({tag, "_write_req"}, 64'(wr), 64'(0));
    check_eq({tag, "_burstbegin"}, 64'(bb), 64'(0));
    check_eq({tag, "_wdata"}, wd, 64'(0));
    check_eq({tag, "_busy"}, 64'(bz), 64'(0));
    check_eq({tag, "_frame_done"}, 64'(dn), 64'(0));
    check_eq({tag, "_size"}, 64'(sz), 64'(16));
    check_eq({tag, "_be"}, 64'(be), 64'(8'hff));
    check_eq({tag, "_addr"}, 64'(ad), 64'(0));
  endtask

  initial begin
    int base;
    vecs[0] = '{lvl: 0,  cycles: 10,  exp_rd: 0, exp_busy: 1'b0};
    vecs[1] = '{lvl: 8,  cycles: 10,  exp_rd: 0, exp_busy: 1'b0};
    vecs[2] = '{lvl: 15, cycles: 100, exp_rd: 0, exp_busy: 1'b0};
    vecs[3] = '{lvl: 16, cycles: 2,   exp_rd: 1, exp_busy: 1'b1};

    rst = 1'b1; fs_a = 1'b0; fs_b = 1'b0; usedw = 8'd0; fifo_data = '0;
    avl_ready = 1'b1; ready_mode = 1'b0; sel = 1'b0; cyc = 0;
    rd_count = 0; acc_count = 0; fd_count = 0; fd_at = -1; tb_beat = 0; exp_addr = 0;

    // Reset values
    reset_dut();
    check_rst("rst_a", rd_a, wr_a, bb_a, wdata_a, busy_a, done_a, size_a, be_a, addr_a);
    check_rst("rst_b", rd_b, wr_b, bb_b, wdata_b, busy_b, done_b, size_b, be_b, addr_b);

    // One burst, 20 words available, ready held high
    set_level(20);
    pulse(1'b0);
    wait_busy(1'b1, 5, "t1_start");
    wait_busy(1'b0, 60, "t1_end");
    repeat (10) tick();
    check_eq("t1_reads", 64'(rd_count), 64'(16));
    check_eq("t1_beats", 64'(acc_count), 64'(16));
    check_eq("t1_left", 64'(usedw), 64'(4));
    check_eq("t1_idle", 64'(busy_a), 64'(0));

    // Same burst with avl_ready pattern 1,0,0
    reset_dut();
    set_level(20);
    ready_mode = 1'b1;
    pulse(1'b0);
    wait_busy(1'b1, 5, "t2_start");
    wait_busy(1'b0, 120, "t2_end");
    ready_mode = 1'b0;
    repeat (5) tick();
    check_eq("t2_reads", 64'(rd_count), 64'(16));
    check_eq("t2_beats", 64'(acc_count), 64'(16));
    check_eq("t2_left", 64'(usedw), 64'(4));

    // 32-beat frame, 40 words: two bursts then frame_done
    sel = 1'b1;
    reset_dut();
    set_level(40);
    pulse(1'b1);
    begin
      int k = 0;
      while (fd_count == 0 && k < 200) begin
        tick();
        k++;
      end
    end
    repeat (40) tick();
    check_eq("t3_done_count", 64'(fd_count), 64'(1));
    check_eq("t3_done_at", 64'(fd_at), 64'(32));
    check_eq("t3_beats", 64'(acc_count), 64'(32));
    check_eq("t3_reads", 64'(rd_count), 64'(32));
    check_eq("t3_left", 64'(usedw), 64'(8));
    check_eq("t3_idle", 64'(busy_b), 64'(0));
    sel = 1'b0;

    // frame_start during the burst at addr 16 restarts at base afterwards
    reset_dut();
    set_level(48);
    pulse(1'b0);
    wait_acc(20, 100, "t4_mid");
    pulse(1'b0);
    wait_acc(32, 60, "t4_b2");
    exp_addr = 0;
    wait_acc(48, 80, "t4_b3");
    wait_busy(1'b0, 10, "t4_end");
    check_eq("t4_done", 64'(fd_count), 64'(0));
    check_eq("t4_sb", 64'(exp_q.size()), 64'(0));

    // Reset during FILL after 5 reads
    reset_dut();
    set_level(20);
    pulse(1'b0);
    begin
      int k = 0;
      while (rd_count < 5 && k < 20) begin
        tick();
        k++;
      end
    end
    check_eq("t5_reads5", 64'(rd_count), 64'(5));
    rst = 1'b1;
    tick();
    check_rst("t5_a", rd_a, wr_a, bb_a, wdata_a, busy_a, done_a, size_a, be_a, addr_a);
    rst = 1'b0;
    exp_q.delete();
    tb_beat = 0;
    set_level(20);
    base = rd_count;
    acc_count = 0;
    repeat (60) tick();
    check_eq("t5_no_write", 64'(acc_count), 64'(0));
    check_eq("t5_no_read", 64'(rd_count - base), 64'(0));
    check_eq("t5_idle", 64'(busy_a), 64'(0));

    // Fill-level threshold table
    set_level(0);
    reset_dut();
    pulse(1'b0);
    for (int i = 0; i < 4; i++) begin
      base = rd_count;
      set_level(vecs[i].lvl);
      repeat (vecs[i].cycles) tick();
      check_eq($sformatf("thr%0d_rd", i), 64'(rd_count - base), 64'(vecs[i].exp_rd));
      check_eq($sformatf("thr%0d_busy", i), 64'(s_busy), 64'(vecs[i].exp_busy));
    end
    wait_busy(1'b0, 60, "t6_end");
    check_eq("t6_beats", 64'(acc_count), 64'(16));
    check_eq("t6_sb", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
